// File: rtl/display_relogio.sv
// display_relogio: 8-slot multiplexed seven-segment driver for an HH:MM:SS clock.
//
// Scans one digit slot per REFRESH_DIV clocks. The seconds/minutes/hours values are
// snapshotted once per frame, at the end of slot 7. Slots 0..5 show the seconds,
// minutes and hours digits, units first. Slots 6..7 are blank.
//
// Optional feature: define PAUSE_BLINK_EN to blank the whole display at a 2 Hz rate
// while `pause` is high. Without the macro, `pause` is ignored.
//
// Ports:
//   clk_100MHz  system clock, rising edge
//   rstn        asynchronous active-low reset
//   segundos    seconds, binary 0..63
//   minutos     minutes, binary 0..63
//   horas       hours, binary 0..63
//   pause       clock-paused level
//   an[7:0]     digit anodes, active-low, an[i] enables slot i
//   seg[6:0]    segments g..a, active-low
//   dp          decimal point, active-low
module display_relogio #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk_100MHz,
  input  logic       rstn,
  input  logic [5:0] segundos,
  input  logic [5:0] minutos,
  input  logic [5:0] horas,
  input  logic       pause,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          presc_tc;
  logic [5:0]    snap_s, snap_m, snap_h;

  logic [7:0]    an_nx;
  logic [6:0]    seg_nx;
  logic          dp_nx;
  logic [3:0]    digit;
  logic [3:0]    s_t, s_u, m_t, m_u, h_t, h_u;
  logic          blank;

  // Tens digit of a 0..63 value.
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if      (v >= 6'd60) tens_of = 4'd6;
    else if (v >= 6'd50) tens_of = 4'd5;
    else if (v >= 6'd40) tens_of = 4'd4;
    else if (v >= 6'd30) tens_of = 4'd3;
    else if (v >= 6'd20) tens_of = 4'd2;
    else if (v >= 6'd10) tens_of = 4'd1;
    else                 tens_of = 4'd0;
  endfunction

  // Units digit is the remainder after subtracting the tens.
  function automatic logic [3:0] units_of(input logic [5:0] v);
    logic [5:0] t10;
    t10 = 6'(tens_of(v)) * 6'd10;
    units_of = 4'(v - t10);
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  always_comb presc_tc = (presc == PW'(REFRESH_DIV - 1));

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      presc  <= '0;
      idx    <= '0;
      snap_s <= '0;
      snap_m <= '0;
      snap_h <= '0;
    end else begin
      if (presc_tc) begin
        presc <= '0;
        idx   <= idx + 3'd1;
        // Capture the time only at the frame boundary, so one frame never mixes two times.
        if (idx == 3'd7) begin
          snap_s <= segundos;
          snap_m <= minutos;
          snap_h <= horas;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

`ifdef PAUSE_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_comb blank = pause & blink_phase;
`else
  logic unused_pause;
  always_comb unused_pause = pause;
  always_comb blank = 1'b0;
`endif

  always_comb begin
    s_t = tens_of(snap_s);
    s_u = units_of(snap_s);
    m_t = tens_of(snap_m);
    m_u = units_of(snap_m);
    h_t = tens_of(snap_h);
    h_u = units_of(snap_h);
  end

  always_comb begin
    an_nx  = '1;
    seg_nx = '1;
    dp_nx  = 1'b1;
    digit  = '0;
    case (idx)
      3'd0:    digit = s_u;
      3'd1:    digit = s_t;
      3'd2:    digit = m_u;
      3'd3:    digit = m_t;
      3'd4:    digit = h_u;
      3'd5:    digit = h_t;
      default: digit = '0;
    endcase
    if (idx <= 3'd5 && !blank) begin
      an_nx[idx] = 1'b0;
      seg_nx     = enc(digit);
      dp_nx      = !(idx == 3'd2 || idx == 3'd4);
    end
  end

  // Outputs are registered from the current index, so they lag an index change by one cycle.
  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else begin
      an  <= an_nx;
      seg <= seg_nx;
      dp  <= dp_nx;
    end
  end

endmodule
